vga_sync_out: RTL and testbench

// Output stage of the VGA display path. Consumes the pixel strobe and the column/row

---
 rtl/vga_sync_out.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_vga_sync_out.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_out.sv
// -----------------------------------------------------------------------------
// vga_sync_out
//
// Output stage of the VGA display path. On each pixel strobe it decodes the
// incoming column/row counts into {active, hsync_n, vsync_n, frame_start}.
// That decode is delayed through RD_LAT+1 pipeline stages so it arrives at the
// output registers together with the framebuffer word for the same pixel. The
// stage also checks that the counts advance one pixel per strobe. If they do
// not, it raises a sticky error and goes idle until the counts return to (0,0).
//
// Parameters
//   RGB_W      pixel word width
//   RD_LAT     pixel strobes between an address issue and its rd_data (0..4)
//   H_* / V_*  horizontal / vertical timing (active, front porch, sync, back porch)
//
// Ports
//   clk          system clock
//   n_rst        synchronous reset, active-high (1 = reset)
//   enable       display enable; 0 flushes the stage and holds it idle
//   pixel_clk    one-clk-wide pixel strobe; the stage advances only on it
//   col_cnt      current column from the display timer
//   row_cnt      current row from the display timer
//   rd_data      framebuffer word for the address issued RD_LAT strobes earlier
//   hsync        horizontal sync, active-low
//   vsync        vertical sync, active-low
//   blank_n      1 = active video pixel on rgb
//   rgb          pixel to the DAC; 0 whenever blank_n = 0
//   frame_start  one-clk pulse when the outputs show pixel (0,0)
//   sync_err     sticky counter-continuity error
// -----------------------------------------------------------------------------
module vga_sync_out #(
  parameter int RGB_W    = 8,
  parameter int RD_LAT   = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             enable,
  input  logic             pixel_clk,
  input  logic [9:0]       col_cnt,
  input  logic [9:0]       row_cnt,
  input  logic [RGB_W-1:0] rd_data,
  output logic             hsync,
  output logic             vsync,
  output logic             blank_n,
  output logic [RGB_W-1:0] rgb,
  output logic             frame_start,
  output logic             sync_err
);

  // ---------------------------------------------------------------------------
  // Timing constants, all pre-sized to the 10-bit count width
  // ---------------------------------------------------------------------------
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  // One pipeline entry: everything the outputs need about a pixel, except its colour.
  typedef struct packed {
    logic act;
    logic hs_n;
    logic vs_n;
    logic fs;
  } ent_t;

  localparam ent_t ENT_IDLE = '{act: 1'b0, hs_n: 1'b1, vs_n: 1'b1, fs: 1'b0};

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;

  logic [9:0]       prev_col_q, prev_col_d;
  logic [9:0]       prev_row_q, prev_row_d;
  ent_t             stg_q [RD_LAT+1];
  ent_t             stg_d [RD_LAT+1];
  ent_t             stg_in [RD_LAT+1];   // value arriving at each stage on a shift
  ent_t             out_ent;

  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             blank_n_q, blank_n_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             frame_start_q, frame_start_d;
  logic             sync_err_q, sync_err_d;

  logic [9:0]       exp_col, exp_row;
  logic             cont_ok;
  logic             at_origin;
  ent_t             dec;

  logic             accept;    // this strobe's decode enters S0 as live video
  logic             set_err;   // continuity broken on this strobe
  logic             flush;     // clear all stages and outputs on this edge
  logic             advance;   // shift the pipeline and reload the outputs

  // ---------------------------------------------------------------------------
  // Continuity check: where the counts must be if the timer is still in step
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default at the top of
  // the block, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    exp_col = (prev_col_q == H_LAST) ? 10'd0 : prev_col_q + 10'd1;
    exp_row = prev_row_q;
    if (prev_col_q == H_LAST) begin
      exp_row = (prev_row_q == V_LAST) ? 10'd0 : prev_row_q + 10'd1;
    end
    // The range checks are redundant while prev is in range, but they keep an
    // out-of-range count from ever being treated as valid.
    cont_ok   = (col_cnt == exp_col) && (row_cnt == exp_row) &&
                (col_cnt <= H_LAST) && (row_cnt <= V_LAST);
    at_origin = (col_cnt == 10'd0) && (row_cnt == 10'd0);
  end

  // ---------------------------------------------------------------------------
  // Decode of the current counts
  // ---------------------------------------------------------------------------
  always_comb begin
    dec      = ENT_IDLE;
    dec.act  = (col_cnt < H_ACT_END) && (row_cnt < V_ACT_END);
    dec.hs_n = !((col_cnt >= H_SYNC_BEG) && (col_cnt <= H_SYNC_END));
    dec.vs_n = !((row_cnt >= V_SYNC_BEG) && (row_cnt <= V_SYNC_END));
    dec.fs   = at_origin;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential blocks use only non-blocking assignments, so every flop
  // samples the values from before the edge, whatever the evaluation order.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else if (pixel_clk) begin
      case (state_q)
        ST_IDLE: if (at_origin) state_d = ST_RUN;
        ST_RUN:  if (!cont_ok)  state_d = ST_IDLE;
        default:                state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (pipeline control)
  // ---------------------------------------------------------------------------
  always_comb begin
    accept  = 1'b0;
    set_err = 1'b0;
    if (enable && pixel_clk) begin
      case (state_q)
        ST_IDLE: accept = at_origin;
        ST_RUN: begin
          accept  = cont_ok;
          set_err = !cont_ok;
        end
        default: accept = 1'b0;
      endcase
    end
    // Disabling needs no strobe. A continuity break flushes on the failing strobe.
    flush   = !enable || set_err;
    advance = pixel_clk && !flush;
  end

  // ---------------------------------------------------------------------------
  // Alignment pipeline S0..S_RD_LAT
  // ---------------------------------------------------------------------------
  always_comb begin
    // While idle, S0 takes blank entries. Anything already in flight drains
    // out normally.
    stg_in[0] = accept ? dec : ENT_IDLE;
    for (int i = 1; i <= RD_LAT; i++) begin
      stg_in[i] = stg_q[i-1];
    end
    for (int i = 0; i <= RD_LAT; i++) begin
      stg_d[i] = flush ? ENT_IDLE : (advance ? stg_in[i] : stg_q[i]);
    end
    // The outputs take the entry as it arrives at the last stage, not after
    // it is stored there. With RD_LAT = 0 this is the live decode, so outputs
    // change on the same strobe edge as the counts.
    out_ent = stg_in[RD_LAT];
  end

  // ---------------------------------------------------------------------------
  // Output and bookkeeping next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    blank_n_d     = blank_n_q;
    rgb_d         = rgb_q;
    frame_start_d = 1'b0;
    if (flush) begin
      hsync_d   = 1'b1;
      vsync_d   = 1'b1;
      blank_n_d = 1'b0;
      rgb_d     = '0;
    end else if (advance) begin
      hsync_d       = out_ent.hs_n;
      vsync_d       = out_ent.vs_n;
      blank_n_d     = out_ent.act;
      rgb_d         = out_ent.act ? rd_data : '0;
      frame_start_d = out_ent.fs;
    end

    sync_err_d = sync_err_q | set_err;
    prev_col_d = accept ? col_cnt : prev_col_q;
    prev_row_d = accept ? row_cnt : prev_row_q;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (n_rst) begin
      // NOTE: the pipeline stages are reset explicitly, unlike a RAM. A stale
      // entry leaving the pipeline after reset would drive sync pulses or
      // frame_start on real pins.
      for (int i = 0; i <= RD_LAT; i++) begin
        stg_q[i] <= ENT_IDLE;
      end
      prev_col_q    <= '0;
      prev_row_q    <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      blank_n_q     <= 1'b0;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      for (int i = 0; i <= RD_LAT; i++) begin
        stg_q[i] <= stg_d[i];
      end
      prev_col_q    <= prev_col_d;
      prev_row_q    <= prev_row_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_n_q     <= blank_n_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank_n     = blank_n_q;
  assign rgb         = rgb_q;
  assign frame_start = frame_start_q;
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_vga_sync_out.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_out
//
// Two instances of vga_sync_out:
//   0: standard 640x480 timing, RD_LAT = 2 (strobe every other clk)
//   1: reduced 8x6 timing (16x12 total), RD_LAT = 0 (strobe every clk), so
//      whole frames fit in a short run
// A frame-level model computes every output from the pixel counts seen at each
// strobe. A compare process checks both instances on every falling edge.
// Directed checks against hand-computed literals also pin the model.
// -----------------------------------------------------------------------------
module tb_vga_sync_out;

  typedef struct packed {
    int ha; int hf; int hs; int hb;
    int va; int vf; int vs; int vb;
    int lat;
  } geo_t;

  localparam geo_t GA = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33, lat: 2};
  localparam geo_t GB = '{ha: 8, hf: 2, hs: 3, hb: 3, va: 6, vf: 2, vs: 2, vb: 2, lat: 0};

  logic       clk = 1'b0;
  logic       n_rst;
  logic [1:0] en, stb, hs, vs, bn, fsp, se;
  logic [9:0] col [2];
  logic [9:0] row [2];
  logic [7:0] rd  [2];
  logic [7:0] rgb [2];

  always #5 clk = ~clk;

  vga_sync_out #(
    .RGB_W(8), .RD_LAT(GA.lat),
    .H_ACTIVE(GA.ha), .H_FP(GA.hf), .H_SYNC(GA.hs), .H_BP(GA.hb),
    .V_ACTIVE(GA.va), .V_FP(GA.vf), .V_SYNC(GA.vs), .V_BP(GA.vb)
  ) dut_a (
    .clk(clk), .n_rst(n_rst), .enable(en[0]), .pixel_clk(stb[0]),
    .col_cnt(col[0]), .row_cnt(row[0]), .rd_data(rd[0]),
    .hsync(hs[0]), .vsync(vs[0]), .blank_n(bn[0]), .rgb(rgb[0]),
    .frame_start(fsp[0]), .sync_err(se[0])
  );

  vga_sync_out #(
    .RGB_W(8), .RD_LAT(GB.lat),
    .H_ACTIVE(GB.ha), .H_FP(GB.hf), .H_SYNC(GB.hs), .H_BP(GB.hb),
    .V_ACTIVE(GB.va), .V_FP(GB.vf), .V_SYNC(GB.vs), .V_BP(GB.vb)
  ) dut_b (
    .clk(clk), .n_rst(n_rst), .enable(en[1]), .pixel_clk(stb[1]),
    .col_cnt(col[1]), .row_cnt(row[1]), .rd_data(rd[1]),
    .hsync(hs[1]), .vsync(vs[1]), .blank_n(bn[1]), .rgb(rgb[1]),
    .frame_start(fsp[1]), .sync_err(se[1])
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic geo_t geo(input int id);
    return (id == 0) ? GA : GB;
  endfunction

  function automatic logic [7:0] rd_pat(input int id, input int c, input int r);
    if (id == 1) return 8'(16 * r + c);
    if (c == 2 && r == 0) return 8'hA5;
    if (c >= 690 && c <= 710) return 8'hFF;
    return 8'(c + 7 * r);
  endfunction

  // ---------------------------------------------------------------------------
  // Model: a log of the counts seen at each strobe, and whether each was
  // accepted as live video. The outputs after strobe n show strobe n-lat,
  // unless a flush happened in between.
  // ---------------------------------------------------------------------------
  typedef struct packed { logic ok; int c; int r; } slot_t;

  slot_t       m_log [2][8];
  int unsigned m_n   [2] = '{0, 0};   // strobes logged so far
  int unsigned m_ff  [2] = '{0, 0};   // first strobe index after the latest flush
  bit          m_run [2] = '{0, 0};
  int          m_lc  [2] = '{0, 0};
  int          m_lr  [2] = '{0, 0};
  logic        m_hs  [2] = '{1'b1, 1'b1};
  logic        m_vs  [2] = '{1'b1, 1'b1};
  logic        m_bn  [2] = '{1'b0, 1'b0};
  logic        m_fs  [2] = '{1'b0, 1'b0};
  logic        m_err [2] = '{1'b0, 1'b0};
  logic [7:0]  m_rgb [2] = '{8'h00, 8'h00};

  task automatic set_idle(input int id);
    m_hs[id]  = 1'b1;
    m_vs[id]  = 1'b1;
    m_bn[id]  = 1'b0;
    m_rgb[id] = 8'h00;
    m_fs[id]  = 1'b0;
  endtask

  task automatic model_step(input int id);
    geo_t  g;
    int    ht, vt, c, r, ec, er;
    bit    bad, valid, act;
    slot_t s, src;
    g  = geo(id);
    ht = g.ha + g.hf + g.hs + g.hb;
    vt = g.va + g.vf + g.vs + g.vb;
    m_fs[id] = 1'b0;
    if (n_rst === 1'b1) begin
      m_run[id] = 0; m_err[id] = 1'b0; m_ff[id] = m_n[id]; set_idle(id);
    end else if (en[id] !== 1'b1) begin
      m_run[id] = 0; m_ff[id] = m_n[id]; set_idle(id);
    end else if (stb[id] === 1'b1) begin
      c = int'(col[id]);
      r = int'(row[id]);
      bad = 0;
      if (m_run[id]) begin
        ec  = (m_lc[id] + 1) % ht;
        er  = (m_lc[id] == ht - 1) ? (m_lr[id] + 1) % vt : m_lr[id];
        bad = (c != ec) || (r != er);
      end
      if (bad) begin
        m_err[id] = 1'b1; m_run[id] = 0; m_ff[id] = m_n[id]; set_idle(id);
      end else begin
        s.ok = m_run[id] || (c == 0 && r == 0);
        s.c  = c;
        s.r  = r;
        m_log[id][m_n[id] % 8] = s;
        if (s.ok) begin
          m_run[id] = 1; m_lc[id] = c; m_lr[id] = r;
        end
        valid = 0;
        src   = s;
        if (m_n[id] >= m_ff[id] + g.lat) begin
          src   = m_log[id][(m_n[id] - g.lat) % 8];
          valid = src.ok;
        end
        m_n[id]++;
        if (valid) begin
          act       = (src.c < g.ha) && (src.r < g.va);
          m_bn[id]  = act;
          m_hs[id]  = !(src.c >= g.ha + g.hf && src.c < g.ha + g.hf + g.hs);
          m_vs[id]  = !(src.r >= g.va + g.vf && src.r < g.va + g.vf + g.vs);
          m_rgb[id] = act ? rd[id] : 8'h00;
          m_fs[id]  = (src.c == 0 && src.r == 0);
        end else begin
          set_idle(id);
        end
      end
    end
  endtask

  always @(posedge clk) begin
    for (int id = 0; id < 2; id++) model_step(id);
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int id = 0; id < 2; id++) begin
        check($sformatf("hsync[%0d]", id),       hs[id],  m_hs[id]);
        check($sformatf("vsync[%0d]", id),       vs[id],  m_vs[id]);
        check($sformatf("blank_n[%0d]", id),     bn[id],  m_bn[id]);
        check($sformatf("rgb[%0d]", id),         rgb[id], m_rgb[id]);
        check($sformatf("frame_start[%0d]", id), fsp[id], m_fs[id]);
        check($sformatf("sync_err[%0d]", id),    se[id],  m_err[id]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instance 0: one idle clk, then one strobe clk. Outputs are read on return.
  task automatic strobe_a(input int c, input int r);
    stb[0] = 1'b0; rd[0] = 8'h5A; tick();
    stb[0] = 1'b1; col[0] = 10'(c); row[0] = 10'(r); rd[0] = rd_pat(0, c, r); tick();
    stb[0] = 1'b0;
  endtask

  // Instance 1: back-to-back strobes.
  task automatic strobe_b(input int c, input int r);
    stb[1] = 1'b1; col[1] = 10'(c); row[1] = 10'(r); rd[1] = rd_pat(1, c, r); tick();
  endtask

  int hs_cnt, hs_first, hs_last;
  int vs_cnt, vs_min, vs_max, fs_cnt;

  initial begin
    n_rst = 1'b1; en = 2'b11; stb = 2'b00;
    col[0] = '0; row[0] = '0; rd[0] = '0;
    col[1] = '0; row[1] = '0; rd[1] = '0;

    // Reset with origin strobes running: reset must win.
    for (int i = 0; i < 3; i++) begin
      stb = 2'b11; rd[0] = 8'hFF; rd[1] = 8'hFF;
      tick();
      chk_on = 1'b1;
    end
    check("rst_hsync",   hs[0],  1'b1);
    check("rst_vsync",   vs[0],  1'b1);
    check("rst_blank_n", bn[0],  1'b0);
    check("rst_rgb",     rgb[0], 8'h00);
    check("rst_sync_err", se[0], 1'b0);
    check("rst_fs_b",    fsp[1], 1'b0);
    n_rst = 1'b0; stb = 2'b00; en = 2'b01;

    // Instance 0: idle until (0,0), then two full lines.
    strobe_a(797, 524); strobe_a(798, 524); strobe_a(799, 524);
    check("idle_wait_blank", bn[0], 1'b0);
    hs_cnt = 0; hs_first = -1; hs_last = -1;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 800; c++) begin
        strobe_a(c, r);
        if (r == 0) begin
          if (hs[0] === 1'b0) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = c;
            hs_last = c;
          end
          if (c == 1) check("latency_blank_c1", bn[0], 1'b0);
          if (c == 2) begin
            check("rgb_a5",      rgb[0], 8'hA5);
            check("blank_c2",    bn[0],  1'b1);
            check("frame_start", fsp[0], 1'b1);
          end
          if (c == 702) check("rgb_col700_zero", rgb[0], 8'h00);
        end
      end
    end
    check("hsync_low_count", hs_cnt,   96);
    check("hsync_first_col", hs_first, 658);
    check("hsync_last_col",  hs_last,  753);

    // Column jump 100 -> 102 on row 2.
    for (int c = 0; c <= 100; c++) strobe_a(c, 2);
    check("pre_jump_err", se[0], 1'b0);
    strobe_a(102, 2);
    check("jump_err",   se[0], 1'b1);
    check("jump_blank", bn[0], 1'b0);
    for (int c = 103; c <= 200; c++) strobe_a(c, 2);
    check("idle_after_err", bn[0], 1'b0);
    for (int c = 0; c <= 2; c++) strobe_a(c, 0);
    check("resume_blank", bn[0],  1'b1);
    check("resume_rgb",   rgb[0], 8'hA5);
    check("err_sticky",   se[0],  1'b1);

    // Reset clears the error. Then drop enable mid-sync.
    n_rst = 1'b1; tick(); n_rst = 1'b0;
    check("rst_clears_err", se[0], 1'b0);
    for (int c = 0; c <= 700; c++) strobe_a(c, 0);
    check("hs_before_drop", hs[0], 1'b0);
    en[0] = 1'b0; tick();
    check("drop_blank_n", bn[0],  1'b0);
    check("drop_rgb",     rgb[0], 8'h00);
    check("drop_hsync",   hs[0],  1'b1);
    check("drop_vsync",   vs[0],  1'b1);
    check("drop_no_err",  se[0],  1'b0);
    en[0] = 1'b1;
    for (int c = 701; c < 800; c++) strobe_a(c, 0);
    for (int c = 0; c <= 10; c++) strobe_a(c, 1);
    check("reenable_idle", bn[0], 1'b0);
    for (int c = 0; c <= 3; c++) strobe_a(c, 0);
    check("reenable_blank", bn[0],  1'b1);
    check("reenable_rgb",   rgb[0], 8'h03);

    // Instance 1: two full frames plus a few strobes, then a count overflow.
    en = 2'b10;
    strobe_b(5, 3);
    check("b_idle_wait", bn[1], 1'b0);
    vs_cnt = 0; vs_min = 99; vs_max = -1; fs_cnt = 0;
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < 12; r++) begin
        for (int c = 0; c < 16; c++) begin
          strobe_b(c, r);
          if (fsp[1] === 1'b1) fs_cnt++;
          if (f == 0) begin
            if (vs[1] === 1'b0) begin
              vs_cnt++;
              if (r < vs_min) vs_min = r;
              if (r > vs_max) vs_max = r;
            end
            if (r == 5 && c == 7) begin
              check("b_active_blank", bn[1],  1'b1);
              check("b_active_rgb",   rgb[1], 8'h57);
            end
            if (r == 0 && c == 8)  check("b_col8_blank", bn[1], 1'b0);
            if (r == 6 && c == 0)  check("b_row6_blank", bn[1], 1'b0);
            if (r == 8 && c == 10) begin
              check("b_hsync_low", hs[1], 1'b0);
              check("b_vsync_low", vs[1], 1'b0);
            end
            if (r == 8 && c == 13) check("b_hsync_end", hs[1], 1'b1);
          end
        end
      end
    end
    for (int c = 0; c < 16; c++) begin
      strobe_b(c, 0);
      if (fsp[1] === 1'b1) fs_cnt++;
    end
    check("b_vsync_low_count", vs_cnt, 32);
    check("b_vsync_first_row", vs_min, 8);
    check("b_vsync_last_row",  vs_max, 9);
    check("b_frame_pulses",    fs_cnt, 3);
    check("b_no_err",          se[1],  1'b0);
    strobe_b(16, 0);
    check("b_overflow_err",   se[1], 1'b1);
    check("b_overflow_blank", bn[1], 1'b0);
    stb[1] = 1'b0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
